// File: rtl/ccff_loader.sv
// Serial configuration-chain loader: takes bitstream bytes and shifts them MSB-first into a chain via prog_clk/ccff_head.
// Define CCFF_LOADER_CRC_EN to add a CRC-8 (poly 0x07) check byte after the chain bits.
`timescale 1ns/1ps
module ccff_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int CLK_DIV   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       prog_clk,
    output logic       ccff_head,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int              PH_W     = $clog2(2 * CLK_DIV);
    localparam logic [PH_W-1:0] PH_RISE  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [15:0]     LAST_BIT = 16'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
`ifdef CCFF_LOADER_CRC_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t          r_state;
    logic [7:0]      r_shreg;
    logic [15:0]     r_bitcnt;
    logic [2:0]      r_bitidx;
    logic [PH_W-1:0] r_phase;
    logic            r_byte_ready;
    logic            r_prog_clk;
    logic            r_head;
    logic            r_busy;
    logic            r_done;

`ifdef CCFF_LOADER_CRC_EN
    logic [7:0]      r_crc;
    logic            r_err;

    function automatic logic [7:0] f_crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign byte_ready = r_byte_ready;
    assign prog_clk   = r_prog_clk;
    assign ccff_head  = r_head;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_shreg      <= 8'd0;
            r_bitcnt     <= 16'd0;
            r_bitidx     <= 3'd0;
            r_phase      <= '0;
            r_byte_ready <= 1'b0;
            r_prog_clk   <= 1'b0;
            r_head       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
            r_crc        <= 8'd0;
            r_err        <= 1'b0;
`endif
        end else if (abort) begin
            r_state      <= S_IDLE;
            r_prog_clk   <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
            r_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_FETCH;
                        r_bitcnt     <= 16'd0;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
`ifdef CCFF_LOADER_CRC_EN
                        r_crc        <= 8'd0;
                        r_err        <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (byte_valid) begin
                        r_shreg      <= byte_in;
                        r_head       <= byte_in[7];
                        r_bitidx     <= 3'd0;
                        r_phase      <= '0;
                        r_byte_ready <= 1'b0;
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Head is presented at phase 0; prog_clk rises at phase CLK_DIV and falls as the bit ends.
                    r_phase <= r_phase + PH_W'(1);
                    if (r_phase == PH_RISE) begin
                        r_prog_clk <= 1'b1;
                    end
                    if (r_phase == PH_LAST) begin
                        r_prog_clk <= 1'b0;
                        r_phase    <= '0;
                        r_bitcnt   <= r_bitcnt + 16'd1;
                        r_bitidx   <= r_bitidx + 3'd1;
                        r_shreg    <= {r_shreg[6:0], 1'b0};
`ifdef CCFF_LOADER_CRC_EN
                        r_crc      <= f_crc8_step(r_crc, r_head);
`endif
                        if (r_bitcnt == LAST_BIT) begin
`ifdef CCFF_LOADER_CRC_EN
                            r_state      <= S_CHECK;
                            r_byte_ready <= 1'b1;
`else
                            r_state      <= S_DONE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
`endif
                        end else if (r_bitidx == 3'd7) begin
                            r_state      <= S_FETCH;
                            r_byte_ready <= 1'b1;
                        end else begin
                            r_head <= r_shreg[6];
                        end
                    end
                end
`ifdef CCFF_LOADER_CRC_EN
                S_CHECK: begin
                    if (byte_valid) begin
                        r_err        <= (byte_in != r_crc);
                        r_done       <= 1'b1;
                        r_busy       <= 1'b0;
                        r_byte_ready <= 1'b0;
                        r_state      <= S_DONE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1024, meaning configuration-chain length in bits, 1..65535.
REQ-002 SHALL have parameter CLK_DIV, default 2, meaning prog_clk half-period in clk cycles, >=1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin load, sampled in IDLE.
REQ-006 SHALL have port abort  input  1  cancel load, any state.
REQ-007 SHALL have port byte_in  input  8  bitstream byte, MSB shifted first.
REQ-008 SHALL have port byte_valid  input  1  byte_in valid.
REQ-009 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port prog_clk  output  1  configuration chain clock.
REQ-011 SHALL have port ccff_head  output  1  configuration chain serial data.
REQ-012 SHALL have port busy  output  1  load in progress.
REQ-013 SHALL have port done  output  1  load completed; held until next start or abort.
REQ-014 SHALL have port err  output  1  CRC mismatch flag, valid while done=1.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, SHIFT, CHECK, DONE.
REQ-016 IDLE: start=1 -> FETCH, clearing bit counter, CRC, done, err; start ignored in all other states.
REQ-017 FETCH: byte_ready=1; byte_valid=1 -> latch byte_in into shift register, -> SHIFT.
REQ-018 SHIFT: each bit takes 2*CLK_DIV clk cycles: ccff_head updated on first cycle with prog_clk=0, prog_clk=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
REQ-019 ccff_head SHALL be stable from CLK_DIV cycles before to CLK_DIV cycles after every prog_clk rising edge.
REQ-020 Exactly CHAIN_LEN prog_clk rising edges SHALL occur per completed load; final byte partial when CHAIN_LEN mod 8 != 0, only its top (CHAIN_LEN mod 8) bits shifted, rest discarded.
REQ-021 After 8 bits (or last bit): remaining bits >0 -> FETCH; else -> CHECK (CRC build) or DONE.
REQ-022 busy=1 in FETCH, SHIFT, CHECK; byte_ready=1 only in FETCH and CHECK.
REQ-023 prog_clk SHALL be 0 in IDLE, FETCH, CHECK, DONE; ccff_head holds last value.
REQ-024 DONE: done=1; start=1 -> FETCH per REQ-016.
REQ-025 abort=1 in any state -> IDLE next cycle, prog_clk=0, done=0, err=0; abort wins over start and byte_valid same cycle.
REQ-026 Bit counter SHALL be 16 bits, no wrap within one load.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, prog_clk=0, ccff_head=0, byte_ready=0, busy=0, done=0, err=0, counters and CRC=0.
REQ-028 Reset mid-SHIFT SHALL abandon load with no further prog_clk edges; no partial-state resume.

Configuration
REQ-029 Macro CCFF_LOADER_CRC_EN SHALL gate the integrity check.
REQ-030 Defined: CRC-8, poly 0x07, init 0x00, over exactly the CHAIN_LEN shifted bits in order; CHECK accepts one extra byte; err=(byte!=CRC); -> DONE.
REQ-031 Undefined: CHECK state and CRC logic absent, last bit -> DONE, err tied 0.

Verification
REQ-032 CHAIN_LEN=16, CLK_DIV=2, bytes 0xA5,0x3C -> 16 prog_clk rises, head sequence 1010010100111100, 64 SHIFT cycles, done=1.
REQ-033 CHAIN_LEN=12, bytes 0xF0,0xAB -> 12 rises, head 111100001010, low nibble 0xB never shifted.
REQ-034 CRC_EN, CHAIN_LEN=8, byte 0x01 then 0x07 -> done=1, err=0; then 0x01 then 0x00 -> done=1, err=1.
REQ-035 abort asserted during 5th bit of first byte -> IDLE next cycle, prog_clk=0, no more rises, done=0; new start loads normally.
REQ-036 rst_n low mid-SHIFT with byte_valid held -> all outputs 0 immediately; start ignored while busy (no restart, bit count unchanged).
